// File: rtl/img_load_ctrl.sv
// Image loader: unpacks serial bytes into the input-unit RAM, runs the core, sends the digit.
// IMG_LOAD_ASCII_EN selects an ASCII result byte instead of a raw nibble.
module img_load_ctrl #(
  parameter int NUM_PIX = 784,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_rdy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              ram_we,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE, UNPACK, START, WAIT_DONE, SEND
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIX - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        byte_reg;
  logic [7:0]        pend_byte;
  logic              pend_vld;
  logic              ovr;
  logic [7:0]        digit_reg;

  logic last_bit, last_pix, have_next;

  assign last_bit  = (bit_cnt == 3'd7);
  assign last_pix  = (wr_cnt == LAST);
  assign have_next = pend_vld | rx_rdy;
  assign busy      = (state != IDLE);
  assign overrun   = ovr;
  assign tx_data   = digit_reg;

  always_comb begin
    state_nx   = state;
    ram_addr   = wr_cnt;
    ram_data   = 1'b0;
    ram_we     = 1'b0;
    core_start = 1'b0;
    tx_start   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_rdy) state_nx = UNPACK;
      end
      UNPACK: begin
        ram_we   = 1'b1;
        ram_data = byte_reg[bit_cnt];
        if (last_bit) begin
          if (last_pix)       state_nx = START;
          else if (have_next) state_nx = UNPACK;
          else                state_nx = IDLE;
        end
      end
      START: begin
        ram_addr   = core_addr;
        core_start = 1'b1;
        state_nx   = WAIT_DONE;
      end
      WAIT_DONE: begin
        ram_addr = core_addr;
        if (core_done) state_nx = SEND;
      end
      SEND: begin
        ram_addr = core_addr;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      bit_cnt   <= '0;
      byte_reg  <= '0;
      pend_byte <= '0;
      pend_vld  <= 1'b0;
      ovr       <= 1'b0;
      digit_reg <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (rx_rdy) begin
            byte_reg <= rx_data;
            bit_cnt  <= '0;
            if (wr_cnt == '0) ovr <= 1'b0;
          end
        end
        UNPACK: begin
          wr_cnt  <= wr_cnt + 1'b1;
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit && last_pix) begin
            // bytes beyond the frame end are discarded
            pend_vld <= 1'b0;
            if (have_next) ovr <= 1'b1;
          end else if (last_bit && have_next) begin
            byte_reg <= pend_vld ? pend_byte : rx_data;
            pend_vld <= pend_vld & rx_rdy;
            if (rx_rdy) pend_byte <= rx_data;
          end else if (rx_rdy) begin
            if (pend_vld) begin
              ovr <= 1'b1;
            end else begin
              pend_vld  <= 1'b1;
              pend_byte <= rx_data;
            end
          end
        end
        START: begin
          wr_cnt  <= '0;
          bit_cnt <= '0;
          if (rx_rdy) ovr <= 1'b1;
        end
        WAIT_DONE: begin
          if (rx_rdy) ovr <= 1'b1;
          if (core_done) begin
`ifdef IMG_LOAD_ASCII_EN
            digit_reg <= 8'h30 + {4'b0000, core_digit};
`else
            digit_reg <= {4'b0000, core_digit};
`endif
          end
        end
        SEND: begin
          if (rx_rdy) ovr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_img_load_ctrl.sv
// Directed self-checking bench for img_load_ctrl.
// Table-driven byte unpack vectors plus hand-written multi-cycle sequences.
module tb_img_load_ctrl;
  localparam int NUM_PIX = 784;
  localparam int ADDR_W  = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_rdy = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data;
  logic              ram_we;
  logic [ADDR_W-1:0] core_addr = '0;
  logic              core_start;
  logic              core_done = 1'b0;
  logic [3:0]        core_digit = '0;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy = 1'b0;
  logic              busy;
  logic              overrun;

  img_load_ctrl #(.NUM_PIX(NUM_PIX), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_rdy(rx_rdy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .core_addr(core_addr), .core_start(core_start),
    .core_done(core_done), .core_digit(core_digit),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    bit d;
    int c;
  } wr_t;

  wr_t        wq[$];
  int         start_cnt = 0;
  int         start_cyc = 0;
  int         tx_cnt = 0;
  int         tx_cyc = 0;
  logic [7:0] tx_seen = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) wq.push_back('{int'(ram_addr), ram_data, cyc});
      if (core_start) begin
        start_cnt = start_cnt + 1;
        start_cyc = cyc;
      end
      if (tx_start) begin
        tx_cnt  = tx_cnt + 1;
        tx_cyc  = cyc;
        tx_seen = tx_data;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic int out_vec();
    return int'({ram_addr, ram_data, ram_we, core_start,
                 tx_data, tx_start, busy, overrun});
  endfunction

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
    int         base;
  } vec_t;

  vec_t tv[4];

  localparam logic [7:0] EXP_TX =
`ifdef IMG_LOAD_ASCII_EN
    8'h37;
`else
    8'h07;
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int b0, s, err, sc0, tc0, drop, found;
    bit pat[8];

    // seq[7] is the bit written to address base, seq[0] to base+7
    tv[0] = '{8'hA5, 8'b10100101, 0};
    tv[1] = '{8'h01, 8'b10000000, 8};
    tv[2] = '{8'h80, 8'b00000001, 16};
    tv[3] = '{8'h0E, 8'b01110000, 24};
    pat = '{1, 0, 1, 0, 0, 1, 0, 1};

    tick();
    chk("reset_outputs", out_vec(), 0);
    do_reset();
    chk("post_reset_outputs", out_vec(), 0);

    for (int v = 0; v < 4; v++) begin
      b0 = wq.size();
      send(tv[v].data);
      s = cyc;
      repeat (11) tick();
      chk($sformatf("vec%0d_writes", v), wq.size() - b0, 8);
      err = 0;
      if (wq.size() - b0 >= 8) begin
        for (int i = 0; i < 8; i++) begin
          if (wq[b0+i].addr != tv[v].base + i) err++;
          if (wq[b0+i].d != tv[v].seq[7-i]) err++;
          if (wq[b0+i].c != s + i) err++;
        end
      end
      chk($sformatf("vec%0d_bits", v), err, 0);
      chk($sformatf("vec%0d_idle", v), int'(busy), 0);
      chk($sformatf("vec%0d_next_addr", v), int'(ram_addr), tv[v].base + 8);
    end

    // back-to-back bytes
    do_reset();
    b0 = wq.size();
    send(8'hFF);
    send(8'h00);
    repeat (20) tick();
    chk("b2b_writes", wq.size() - b0, 16);
    err = 0;
    if (wq.size() - b0 >= 16) begin
      for (int i = 0; i < 16; i++) begin
        if (wq[b0+i].addr != i) err++;
        if (wq[b0+i].d != (i < 8)) err++;
        if (wq[b0+i].c != wq[b0].c + i) err++;
      end
    end
    chk("b2b_bits_nogap", err, 0);
    chk("b2b_overrun", int'(overrun), 0);

    // overrun: third consecutive byte is dropped
    do_reset();
    b0 = wq.size();
    send(8'hFF);
    send(8'h00);
    send(8'hAA);
    repeat (20) tick();
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_writes", wq.size() - b0, 16);
    err = 0;
    if (wq.size() - b0 >= 16)
      for (int i = 0; i < 16; i++)
        if (wq[b0+i].d != (i < 8)) err++;
    chk("ovr_bits", err, 0);
    chk("ovr_idle", int'(busy), 0);

    // full frame of 8'hA5
    do_reset();
    b0  = wq.size();
    sc0 = start_cnt;
    for (int k = 0; k < NUM_PIX / 8; k++) begin
      send(8'hA5);
      repeat (19) tick();
    end
    chk("frame_writes", wq.size() - b0, NUM_PIX);
    err = 0;
    if (wq.size() - b0 >= NUM_PIX) begin
      for (int i = 0; i < NUM_PIX; i++) begin
        if (wq[b0+i].addr != i) err++;
        if (wq[b0+i].d != pat[i%8]) err++;
      end
      chk("frame_start_cycle", start_cyc, wq[b0+NUM_PIX-1].c + 1);
    end
    chk("frame_pattern", err, 0);
    chk("frame_start_count", start_cnt - sc0, 1);

    // mux during WAIT_DONE
    core_addr = 10'd300;
    tick();
    chk("mux_addr", int'(ram_addr), 300);
    chk("mux_we", int'(ram_we), 0);
    chk("mux_busy", int'(busy), 1);
    drop = wq.size();
    send(8'h12);
    tick();
    chk("late_rx_overrun", int'(overrun), 1);
    chk("late_rx_no_write", wq.size() - drop, 0);

    // result path with busy transmitter
    tc0        = tx_cnt;
    tx_busy    = 1'b1;
    core_digit = 4'd7;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
    core_digit = 4'd0;
    chk("tx_data_d1", int'(tx_data), int'(EXP_TX));
    repeat (5) tick();
    chk("tx_held", tx_cnt - tc0, 0);
    tx_busy = 1'b0;
    s = cyc;
    tick();
    chk("tx_count", tx_cnt - tc0, 1);
    chk("tx_cycle", tx_cyc, s);
    chk("tx_seen", int'(tx_seen), int'(EXP_TX));
    repeat (3) tick();
    chk("tx_once", tx_cnt - tc0, 1);
    chk("tx_idle", int'(busy), 0);

    // next frame restarts at 0 and clears overrun
    b0 = wq.size();
    send(8'h01);
    repeat (10) tick();
    chk("nf_overrun_clr", int'(overrun), 0);
    chk("nf_writes", wq.size() - b0, 8);
    if (wq.size() > b0) begin
      chk("nf_addr0", wq[b0].addr, 0);
      chk("nf_data0", int'(wq[b0].d), 1);
    end

    // reset at bit 3 of byte 50
    do_reset();
    for (int k = 0; k < 50; k++) begin
      send(8'h55);
      repeat (9) tick();
    end
    send(8'hC3);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_we && ram_addr == 10'd403) begin
        found = 1;
        break;
      end
    end
    chk("rst_mid_reach", found, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_outputs", out_vec(), 0);
    drop = wq.size();
    tick();
    tick();
    chk("rst_mid_no_write", wq.size() - drop, 0);
    rst = 1'b0;
    tick();
    b0 = wq.size();
    send(8'h0F);
    repeat (10) tick();
    chk("rst_nf_writes", wq.size() - b0, 8);
    if (wq.size() > b0) begin
      chk("rst_nf_addr0", wq[b0].addr, 0);
      chk("rst_nf_data0", int'(wq[b0].d), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/img_load_ctrl.md
# img_load_ctrl

Front-end controller that feeds the input-unit RAM read by `snn_core`. It receives a 784-pixel, 1-bit-per-pixel image as 98 serial bytes, unpacks them LSB-first, and writes them into the input-unit RAM. It then pulses `snn_core` start, waits for done, latches the classified digit, and hands one result byte to the UART transmitter. It owns the RAM address mux, so the core reads the RAM only after loading is complete.

## Interface
Parameters:
- `NUM_PIX`, 784: pixels per image; must be a multiple of 8.
- `ADDR_W`, 10: input-unit RAM address width.

Ports:
- `clk`  in  1: single system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `rx_data`  in  8: received byte.
- `rx_rdy`  in  1: one-cycle pulse; `rx_data` is valid this cycle.
- `ram_addr`  out  ADDR_W: input-unit RAM address.
- `ram_data`  out  1: pixel bit to write.
- `ram_we`  out  1: RAM write enable.
- `core_addr`  in  ADDR_W: read address from the core's `addr_in_unit`.
- `core_start`  out  1: one-cycle start pulse to the core.
- `core_done`  in  1: core completion pulse.
- `core_digit`  in  4: core result; valid when `core_done` is high.
- `tx_data`  out  8: result byte.
- `tx_start`  out  1: one-cycle transmit request.
- `tx_busy`  in  1: transmitter is occupied.
- `busy`  out  1: high in any state other than IDLE.
- `overrun`  out  1: sticky dropped-byte flag.

## Operation
- States: IDLE, UNPACK, START, WAIT_DONE, SEND.
- IDLE:
  - On `rx_rdy`, capture `rx_data` into `byte_reg` and go to UNPACK.
  - If this is byte 0 of a frame, clear `overrun`.
- UNPACK (8 cycles per byte):
  - `ram_we`=1, `ram_addr`=`wr_cnt`, `ram_data`=`byte_reg[bit_cnt]`.
  - `wr_cnt` and `bit_cnt` increment each cycle.
  - Pixel address is 8·k+i for bit i of byte k.
- After bit 7 of a byte:
  - If `wr_cnt` reached `NUM_PIX`, go to START.
  - Else if the pending byte is valid, load it into `byte_reg` and stay in UNPACK.
  - Else return to IDLE and wait for the next byte.
- Pending buffer:
  - One-deep; captures `rx_rdy` that arrives during UNPACK.
  - If `rx_rdy` arrives while pending is already full, the byte is dropped and `overrun` is set.
- START: `core_start`=1 for exactly one cycle; clear `wr_cnt`; go to WAIT_DONE.
- WAIT_DONE: on `core_done`, latch `core_digit` into `digit_reg` and go to SEND.
- SEND: when `tx_busy`=0, pulse `tx_start` for one cycle and go to IDLE. While `tx_busy`=1, hold in SEND.
- `rx_rdy` in START, WAIT_DONE or SEND is dropped and sets `overrun`. The frame in progress is unaffected.
- RAM address mux: `ram_addr`=`wr_cnt` in IDLE and UNPACK, and `core_addr` in START, WAIT_DONE and SEND. `ram_we`=0 outside UNPACK.
- Frame boundary: the byte counter spans frames only through IDLE. Partial frames persist until completed or until `rst`; there is no timeout.

## Timing
- Reset values: state IDLE, `wr_cnt`=0, `bit_cnt`=0, pending empty. All outputs are 0: `ram_addr`, `ram_data`, `ram_we`, `core_start`, `tx_data`, `tx_start`, `busy`, `overrun`.
- `rx_rdy` at edge t puts the first write (bit 0) in cycle t+1. The last write for that byte is in cycle t+8.
- The final pixel write (address `NUM_PIX`−1) is followed by `core_start` in the next cycle.
- `core_done` at edge d:
  - `digit_reg` and `tx_data` are valid from d+1.
  - `tx_start` is asserted at d+1 if `tx_busy`=0.
- `rst` asserted mid-operation: immediate return to IDLE with counters cleared and no further RAM writes. The core is not notified.

## Configuration
- `IMG_LOAD_ASCII_EN` defined: `tx_data` = 8'h30 + `digit_reg` (ASCII '0'–'9').
- `IMG_LOAD_ASCII_EN` not defined: `tx_data` = {4'b0000, `digit_reg`}.

## Test plan
- Full frame: 98 bytes of 8'hA5 spaced 20 cycles apart. Required:
  - 784 writes with `ram_data` pattern 1,0,1,0,0,1,0,1 repeating.
  - `core_start` exactly once, one cycle after the address-783 write.
- Back-to-back bytes: two `rx_rdy` pulses 1 cycle apart (8'hFF, 8'h00). Required:
  - Addresses 0–7 get 1, addresses 8–15 get 0.
  - No gap cycle between the two bytes; `overrun`=0.
- Overrun: three `rx_rdy` pulses on consecutive cycles. Required: the third byte is dropped, `overrun`=1, and 16 writes occur.
- Result path: `core_done` with `core_digit`=7 while `tx_busy`=1 for 5 cycles. Required: `tx_start` fires once, on the first cycle `tx_busy`=0, with `tx_data`=8'h37 (8'h07 without the macro).
- Mux: during WAIT_DONE, drive `core_addr`=10'd300. Required: `ram_addr`=300 and `ram_we`=0.
- Reset mid-UNPACK: assert `rst` at bit 3 of byte 50. Required: all outputs are 0 immediately. The next frame starts writing at address 0.
